// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-path definitions: widths, reset PC default, NOP encoding and
// the prefetch queue entry layout {PC, IR}.
package if_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Parameterised synchronous FIFO with synchronous flush (flush wins over
// read/write) and occupancy count; storage is cleared on reset so the head
// reads as zero until the first write.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues reads to a 1-cycle
// instruction memory and presents buffered {PC, IR} pairs to IF/ID.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               CLR,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               EN,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_IR,
  output logic [ADDR_W-1:0]  out_PC,
  output logic [ADDR_W-1:0]  out_PC4,
  output logic               bubble
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] issued_pc;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              deq;
  logic [CNT_W:0]    occ;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

  assign out_valid = ~empty;
  assign bubble    = empty;
  assign deq       = EN & out_valid;

  // Slots already claimed (queued + in flight) net of this cycle's dequeue;
  // issuing only below DEPTH makes overflow impossible.
  assign occ = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, deq};

  assign imem_req  = CLR & ~redirect & (occ < (CNT_W + 1)'(DEPTH));
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      fetch_pc  <= RESET_PC;
      issued_pc <= '0;
      inflight  <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'h0000_0003;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc  <= fetch_pc + 32'd4;
        issued_pc <= fetch_pc;
      end
    end
  end

  assign wr_entry.pc = issued_pc;
  assign wr_entry.ir = imem_rdata;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (CLR),
    .flush   (redirect),
    .wr_en   (inflight & ~redirect),
    .wr_data (wr_entry),
    .rd_en   (deq & ~redirect),
    .rd_data (head),
    .count   (count),
    .empty   (empty)
  );

  assign out_IR  = head.ir;
  assign out_PC  = head.pc;
  assign out_PC4 = head.pc + 32'd4;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: memory returns addr ^ 32'hA5A5_0000,
// each step advances one cycle and compares against hand-computed values.
module tb_if_fetch_queue;

  logic        clk;
  logic        CLR;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        EN;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_IR;
  logic [31:0] out_PC;
  logic [31:0] out_PC4;
  logic        bubble;

  int checks;
  int failures;

  if_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .CLR         (CLR),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .EN          (EN),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_IR      (out_IR),
    .out_PC      (out_PC),
    .out_PC4     (out_PC4),
    .bubble      (bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ 32'hA5A5_0000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic rd, input logic [31:0] rd_pc);
    @(posedge clk);
    #2;
    EN          = en;
    redirect    = rd;
    redirect_pc = rd_pc;
    #1;
  endtask

  task automatic reset_dut(input logic en);
    @(posedge clk);
    #2;
    CLR         = 1'b0;
    EN          = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #2;
    CLR = 1'b1;
    EN  = en;
    #1;
  endtask

  task automatic exp_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic exp_out(input string tag, input logic valid, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, valid});
    chk({tag, ".bubble"}, {31'd0, bubble}, {31'd0, ~valid});
    if (valid) begin
      chk({tag, ".pc"}, out_PC, pc);
      chk({tag, ".ir"}, out_IR, pc ^ 32'hA5A5_0000);
      chk({tag, ".pc4"}, out_PC4, pc + 32'd4);
    end
  endtask

  task automatic exp_reset_vals(input string tag);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".bubble"}, {31'd0, bubble}, 32'd1);
    chk({tag, ".ir"}, out_IR, 32'd0);
    chk({tag, ".pc"}, out_PC, 32'd0);
    chk({tag, ".pc4"}, out_PC4, 32'd4);
    chk({tag, ".req"}, {31'd0, imem_req}, 32'd0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    CLR         = 1'b0;
    EN          = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rdata  = '0;
    #13;
    exp_reset_vals("rst");

    // 1: steady fetch
    reset_dut(1'b1);
    exp_req("t1c0", 1'b1, 32'h0);
    exp_out("t1c0", 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    exp_req("t1c1", 1'b1, 32'h4);
    exp_out("t1c1", 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    exp_req("t1c2", 1'b1, 32'h8);
    exp_out("t1c2", 1'b1, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    exp_req("t1c3", 1'b1, 32'hC);
    exp_out("t1c3", 1'b1, 32'h4);
    cyc(1'b1, 1'b0, 32'h0);
    exp_out("t1c4", 1'b1, 32'h8);

    // 2: stall fills queue to DEPTH, then drains in order
    reset_dut(1'b1);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    exp_req("t2c2", 1'b1, 32'h8);
    exp_out("t2c2", 1'b1, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    exp_req("t2c3", 1'b1, 32'hC);
    cyc(1'b0, 1'b0, 32'h0);
    exp_req("t2c4", 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    exp_req("t2c5", 1'b0, 32'h0);
    exp_out("t2c5", 1'b1, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    exp_req("t2c6", 1'b1, 32'h10);
    exp_out("t2c6", 1'b1, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      exp_out("t2drain", 1'b1, 32'(i * 4));
    end

    // 4: stall until full, then redirect with EN=0
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      exp_out("t4hold", 1'b1, 32'h18);
    end
    exp_req("t4full", 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h40);
    exp_req("t4rd", 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    exp_out("t4a", 1'b0, 32'h0);
    exp_req("t4a", 1'b1, 32'h40);
    cyc(1'b0, 1'b0, 32'h0);
    exp_out("t4b", 1'b0, 32'h0);
    exp_req("t4b", 1'b1, 32'h44);
    cyc(1'b1, 1'b0, 32'h0);
    exp_out("t4c", 1'b1, 32'h40);
    cyc(1'b1, 1'b0, 32'h0);
    exp_out("t4d", 1'b1, 32'h44);
    cyc(1'b1, 1'b0, 32'h0);
    exp_out("t4e", 1'b1, 32'h48);

    // 3: redirect with a read in flight; target bits [1:0] dropped
    reset_dut(1'b1);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h0000_0102);
    exp_req("t3rd", 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    exp_out("t3a", 1'b0, 32'h0);
    exp_req("t3a", 1'b1, 32'h100);
    cyc(1'b1, 1'b0, 32'h0);
    exp_out("t3b", 1'b0, 32'h0);
    exp_req("t3b", 1'b1, 32'h104);
    cyc(1'b1, 1'b0, 32'h0);
    exp_out("t3c", 1'b1, 32'h100);
    cyc(1'b1, 1'b0, 32'h0);
    exp_out("t3d", 1'b1, 32'h104);

    // 5: back-to-back redirects, last wins
    reset_dut(1'b1);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h200);
    exp_req("t5rd1", 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h300);
    exp_req("t5rd2", 1'b0, 32'h0);
    exp_out("t5rd2", 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    exp_req("t5a", 1'b1, 32'h300);
    exp_out("t5a", 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    exp_req("t5b", 1'b1, 32'h304);
    exp_out("t5b", 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      exp_out("t5out", 1'b1, 32'h300 + 32'(i * 4));
    end

    // 6: asynchronous reset mid-stream with queue partly filled
    reset_dut(1'b1);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    exp_out("t6pre", 1'b1, 32'h0);
    #1;
    CLR = 1'b0;
    #1;
    exp_reset_vals("t6async");
    reset_dut(1'b1);
    exp_req("t6c0", 1'b1, 32'h0);
    exp_out("t6c0", 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    exp_req("t6c1", 1'b1, 32'h4);
    cyc(1'b1, 1'b0, 32'h0);
    exp_out("t6c2", 1'b1, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    exp_out("t6c3", 1'b1, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
